// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: framer states, sample points
// and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam int unsigned DEF_BIT_CELLS = 16;
    localparam int unsigned SAMPLE_A      = 7;
    localparam int unsigned SAMPLE_B      = 8;
    localparam int unsigned VOTE_CNT      = 9;
    localparam int unsigned LAST_CNT      = DEF_BIT_CELLS - 1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head is read combinationally from storage; a push
// and a pop in the same cycle both take effect, even when full.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_l,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    always_comb begin
        full   = (count == (AW + 1)'(DEPTH));
        empty  = (count == '0);
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
        head   = mem[rdPtr];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= push_data;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: 2-flop synchronizer, 16x-oversampled framer with majority
// voting and stop-bit check, feeding a small show-ahead FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned WORD_LEN   = 8,
    parameter int unsigned BIT_CELLS  = DEF_BIT_CELLS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_l,
    input  logic                          uart_dataH,
    output logic [WORD_LEN-1:0]           rx_dataH,
    output logic                          rx_validH,
    input  logic                          rx_popH,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_countH,
    output logic                          frame_errH,
    output logic                          overrunH
);

    localparam int unsigned CW = $clog2(BIT_CELLS);
    localparam int unsigned BW = $clog2(WORD_LEN + 2);

    localparam logic [CW-1:0] sampleA = CW'(SAMPLE_A);
    localparam logic [CW-1:0] sampleB = CW'(SAMPLE_B);
    localparam logic [CW-1:0] voteCnt = CW'(VOTE_CNT);
    localparam logic [CW-1:0] lastCnt = CW'(BIT_CELLS - 1);
    localparam logic [BW-1:0] lastBit = BW'(WORD_LEN);

    logic                syncMeta;
    logic                rxs;
    rxState_t            state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bidx;
    logic                s7;
    logic                s8;
    logic                vote;
    logic [WORD_LEN-1:0] shiftReg;
    logic                pushReq;
    logic                fifoFull;
    logic                fifoEmpty;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            syncMeta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            syncMeta <= uart_dataH;
            rxs      <= syncMeta;
        end
    end

    always_comb begin
        vote      = majority3(s7, s8, rxs);
        pushReq   = (state == STOP) && (cnt == voteCnt) && vote;
        rx_validH = !fifoEmpty;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            cnt        <= '0;
            bidx       <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            shiftReg   <= '0;
            frame_errH <= 1'b0;
            overrunH   <= 1'b0;
        end else begin
            frame_errH <= 1'b0;
            overrunH   <= 1'b0;
            if (cnt == sampleA) s7 <= rxs;
            if (cnt == sampleB) s8 <= rxs;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    bidx <= '0;
                    // The detection cycle itself is cell count 0.
                    if (!rxs) begin
                        state <= START;
                        cnt   <= CW'(1);
                    end
                end
                START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == voteCnt && vote) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == lastCnt) begin
                        state <= DATA;
                        bidx  <= BW'(1);
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == voteCnt) begin
                        shiftReg <= {vote, shiftReg[WORD_LEN-1:1]};
                    end
                    if (cnt == lastCnt) begin
                        bidx <= bidx + 1'b1;
                        if (bidx == lastBit) state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt + 1'b1;
                    // Leave at mid-stop so the next falling edge resyncs.
                    if (cnt == voteCnt) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (!vote) begin
                            frame_errH <= 1'b1;
                        end else if (fifoFull && !rx_popH) begin
                            overrunH <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (WORD_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .push      (pushReq),
        .push_data (shiftReg),
        .pop       (rx_popH),
        .head      (rx_dataH),
        .count     (fifo_countH),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed and randomized frames against a queue-based model of the receiver.
module tb_uart_rx_buffered;

    logic       sys_clk = 1'b0;
    logic       sys_rst_l;
    logic       uart_dataH;
    logic [7:0] rx_dataH;
    logic       rx_validH;
    logic       rx_popH;
    logic [2:0] fifo_countH;
    logic       frame_errH;
    logic       overrunH;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    always #5 sys_clk = ~sys_clk;

    uart_rx_buffered dut (
        .sys_clk     (sys_clk),
        .sys_rst_l   (sys_rst_l),
        .uart_dataH  (uart_dataH),
        .rx_dataH    (rx_dataH),
        .rx_validH   (rx_validH),
        .rx_popH     (rx_popH),
        .fifo_countH (fifo_countH),
        .frame_errH  (frame_errH),
        .overrunH    (overrunH)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " data0"}, 32'(rx_dataH), 32'd0);
        check({tag, " valid0"}, 32'(rx_validH), 32'd0);
        check({tag, " count0"}, 32'(fifo_countH), 32'd0);
        check({tag, " ferr0"}, 32'(frame_errH), 32'd0);
        check({tag, " ovr0"}, 32'(overrunH), 32'd0);
    endtask

    // One frame (start, 8 data LSB first, stop) plus an idle gap, 16 cycles per bit.
    // Index k counts negedges from the one that drives the start bit.
    task automatic runFrame(input logic [7:0] b, input logic stopBit, input bit glitch,
                            input int popAt, input int rstAt, input string tag);
        int   errCnt = 0;
        int   ovrCnt = 0;
        bit   expErr = 1'b0;
        bit   expOvr = 1'b0;
        int   idx;
        logic v;
        for (int k = 0; k < 180; k++) begin
            @(negedge sys_clk);
            if (frame_errH === 1'b1) errCnt++;
            if (overrunH === 1'b1) ovrCnt++;
            if (k == 155) begin
                check({tag, " count before push"}, 32'(fifo_countH), 32'(q.size()));
                check({tag, " valid before push"}, 32'(rx_validH), 32'(q.size() != 0));
            end
            if (k == 156) begin
                expErr = (rstAt < 0) && !stopBit;
                if (rstAt < 0 && stopBit) begin
                    if (q.size() == 4) expOvr = 1'b1;
                    else q.push_back(b);
                end
                check({tag, " count after push"}, 32'(fifo_countH), 32'(q.size()));
                check({tag, " valid after push"}, 32'(rx_validH), 32'(q.size() != 0));
                if (q.size() != 0) check({tag, " head"}, 32'(rx_dataH), 32'(q[0]));
                check({tag, " frame_err at stop"}, 32'(frame_errH), 32'(expErr));
                check({tag, " overrun at stop"}, 32'(overrunH), 32'(expOvr));
            end
            if (rstAt >= 0 && k == rstAt + 1) checkAllZero({tag, " after reset"});
            if (popAt >= 0 && popAt != 155 && k == popAt + 1)
                check({tag, " count after pop"}, 32'(fifo_countH), 32'(q.size()));
            idx = k / 16;
            if (idx == 0) v = 1'b0;
            else if (idx <= 8) v = b[idx-1];
            else if (idx == 9) v = stopBit;
            else v = 1'b1;
            if (glitch && idx >= 1 && idx <= 8 && (k % 16) == 8) v = ~v;
            if (k == popAt && q.size() != 0) begin
                check({tag, " head at pop"}, 32'(rx_dataH), 32'(q[0]));
                void'(q.pop_front());
            end
            if (k == rstAt) q.delete();
            rx_popH    = (k == popAt);
            sys_rst_l  = (k != rstAt);
            uart_dataH = v;
        end
        check({tag, " frame_err pulses"}, 32'(errCnt), 32'(expErr));
        check({tag, " overrun pulses"}, 32'(ovrCnt), 32'(expOvr));
    endtask

    task automatic popOne(input string tag);
        @(negedge sys_clk);
        check({tag, " valid"}, 32'(rx_validH), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, " head"}, 32'(rx_dataH), 32'(q[0]));
            void'(q.pop_front());
        end
        rx_popH = 1'b1;
        @(negedge sys_clk);
        rx_popH = 1'b0;
        check({tag, " count"}, 32'(fifo_countH), 32'(q.size()));
        check({tag, " valid after"}, 32'(rx_validH), 32'(q.size() != 0));
    endtask

    initial begin
        int flagCnt;
        int sel;
        int popAt;
        sys_rst_l  = 1'b0;
        uart_dataH = 1'b1;
        rx_popH    = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_l = 1'b1;
        @(negedge sys_clk);
        checkAllZero("reset");
        repeat (4) @(negedge sys_clk);

        runFrame(8'hA5, 1'b1, 1'b0, -1, -1, "a5");
        popOne("a5 pop");
        popOne("empty pop");

        // Short low spike while idle must be rejected silently.
        flagCnt = 0;
        @(negedge sys_clk);
        uart_dataH = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_dataH = 1'b1;
        repeat (40) begin
            @(negedge sys_clk);
            if (frame_errH === 1'b1 || overrunH === 1'b1) flagCnt++;
        end
        check("spike flags", 32'(flagCnt), 32'd0);
        check("spike count", 32'(fifo_countH), 32'd0);

        runFrame(8'h3C, 1'b0, 1'b0, -1, -1, "3c ferr");

        for (int i = 1; i <= 5; i++) runFrame(8'(i), 1'b1, 1'b0, -1, -1, "fill");
        for (int i = 0; i < 4; i++) popOne("drain");
        popOne("drain empty");

        for (int i = 1; i <= 4; i++) runFrame(8'(i), 1'b1, 1'b0, -1, -1, "fill2");
        runFrame(8'h05, 1'b1, 1'b0, 155, -1, "fill2 push+pop");
        for (int i = 0; i < 4; i++) popOne("drain2");

        runFrame(8'h96, 1'b1, 1'b1, -1, -1, "96 glitch");
        popOne("96 pop");

        runFrame(8'h11, 1'b1, 1'b0, -1, -1, "pre-reset");
        runFrame(8'hFF, 1'b1, 1'b0, -1, 85, "ff reset");
        runFrame(8'h5A, 1'b1, 1'b0, -1, -1, "5a");
        popOne("5a pop");

        for (int i = 0; i < 14; i++) begin
            sel = int'($urandom_range(0, 2));
            popAt = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(20, 150)) : 155;
            runFrame(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                     popAt, -1, "rand");
        end
        while (q.size() != 0) popOne("rand drain");
        popOne("final empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Stand-alone UART receive path: 16x-oversampled start/data/stop framing with 3-sample majority voting, stop-bit (framing) checking, and a small show-ahead receive FIFO. It accepts the serial line driven by the team's UART transmitter (LSB first, one start bit, one stop bit, 16 clocks per bit). It replaces the bare shift-register receiver in the top-level UART wrapper, so the host side can pop bytes without real-time servicing.

## Interface
- WORD_LEN, 8, data bits per frame
- BIT_CELLS, 16, sys_clk cycles per bit cell
- FIFO_DEPTH, 4, receive FIFO entries (power of two)
- sys_clk  in  1  single clock, rising edge
- sys_rst_l  in  1  reset, synchronous, active-low
- uart_dataH  in  1  asynchronous serial line, idle high
- rx_dataH  out  WORD_LEN  FIFO head byte, valid when rx_validH=1
- rx_validH  out  1  FIFO non-empty
- rx_popH  in  1  consume head byte this cycle; ignored when empty
- fifo_countH  out  $clog2(FIFO_DEPTH)+1  bytes stored
- frame_errH  out  1  one-cycle pulse: stop bit sampled low
- overrunH  out  1  one-cycle pulse: good frame dropped, FIFO full

## Operation
- 2-flop synchronizer on uart_dataH, both flops reset to 1; all logic uses the synchronized value `rxs`.
- Cell counter `cnt` (4 bits), incrementing every cycle outside IDLE, wraps 15->0 at bit boundary; bit index `bidx` 0=start, 1..WORD_LEN=data, WORD_LEN+1=stop.
- Majority vote: `rxs` registered at cnt=7 and cnt=8; at cnt=9 vote = majority(s7, s8, rxs).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `rxs`=0 -> START. The detection cycle counts as cnt=0; cnt=1 next cycle.
  - START: at cnt=9, vote=0 -> DATA; vote=1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt=9, shift vote in at the MSB, shift right (LSB first). After bit WORD_LEN, at cnt=15 wrap -> STOP.
  - STOP: at cnt=9, vote=1 -> push byte into FIFO, then IDLE. vote=0 -> frame_errH pulse, no push, then IDLE.
  - Early return to IDLE at stop mid-bit is required. It allows resync on the next falling edge.
- FIFO is show-ahead: rx_dataH shows the head combinationally from the storage registers.
  - Pop when empty: no effect.
  - Push when full without a pop: byte dropped, overrunH pulse, contents unchanged.
  - Push and pop in the same cycle: both take effect. Count is unchanged, including when full (no overrun).
- Pointer wrap: modulo FIFO_DEPTH. Count saturates at FIFO_DEPTH by construction.

## Timing
- Reset (sys_rst_l=0 at a sys_clk edge): state IDLE, cnt=0, shift register 0, FIFO empty. Outputs: rx_dataH=0, rx_validH=0, fifo_countH=0, frame_errH=0, overrunH=0.
- Reset mid-frame aborts the frame; no push, no flag.
- Detection: line low at edge E -> `rxs` low after E+2 -> that cycle is T0 (IDLE, cnt=0).
- Stop vote occurs in cycle T0 + (WORD_LEN+1)*16 + 9 = T0+153 for defaults.
  - Push, frame_errH or overrunH are registered there and visible in cycle T0+154.
  - rx_validH rises in T0+154.
- Pop: rx_popH high in cycle N -> count/head update visible in N+1.
- Flags are registered, high for exactly one cycle per frame.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP).
  - Constants: SAMPLE_A=7, SAMPLE_B=8, VOTE_CNT=9, LAST_CNT=BIT_CELLS-1.
- One sub-module `uart_rx_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, push_data, pop, head, count, full, empty.
  - Synchronous active-low reset.
- Framer FSM, counters and synchronizer live in the top module.

## Test plan
- Frame 0xA5 at 16 clk/bit, stop=1 -> rx_validH=1 and rx_dataH=0xA5 at T0+154, fifo_countH=1; pulse rx_popH -> rx_validH=0 next cycle.
- Line low for 3 cycles while idle -> START entered, vote=1 -> IDLE; no push, no flags, fifo_countH=0.
- Frame 0x3C with stop bit driven 0 -> frame_errH one-cycle pulse at T0+154; fifo_countH stays 0.
- Five frames 0x01..0x05, no pops:
  - fifo_countH=4; overrunH pulses on the fifth frame.
  - Pops return 0x01,0x02,0x03,0x04.
  - Repeat with rx_popH asserted in the fifth push cycle -> no overrun, count stays 4, 0x05 stored.
- Frame 0x96 with a single-cycle inversion at cnt=8 of every data bit -> rx_dataH=0x96, no flags.
- sys_rst_l low for one edge during data bit 4 of frame 0xFF -> all outputs 0, state IDLE; following frame 0x5A received intact.
